// File: rtl/versatile_mem_ctrl_ddr_rd_align_pkg.sv
// Shared controller constants for the DDR2 read path: burst-length encodings,
// default CAS latency and read tag width.
package versatile_mem_ctrl_ddr_rd_align_pkg;

  localparam int DAT_W     = 32;
  localparam int CL_DEF    = 3;
  localparam int TAG_W_DEF = 2;

  // DDR2 mode-register BL field values
  typedef enum logic [2:0] {
    BL_4 = 3'b010,
    BL_8 = 3'b011
  } bl_enc_e;

  // Two beats (rise + fall) are packed into one 32-bit word
  function automatic int bl_words(input int bl);
    return bl / 2;
  endfunction

endpackage

// File: rtl/versatile_mem_ctrl_ddr_rd_align_if.sv
// Read-return bus between the PHY capture side, the aligner and the Rx FIFO.
interface versatile_mem_ctrl_ddr_rd_align_if
  import versatile_mem_ctrl_ddr_rd_align_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
);

  logic             rd_cmd_i;
  logic [TAG_W-1:0] rd_tag_i;
  logic [DAT_W-1:0] rx_dat_i;
  logic             fifo_full_i;
  logic             err_clr_i;
  logic [DAT_W-1:0] rd_dat_o;
  logic             rd_vld_o;
  logic             rd_last_o;
  logic [TAG_W-1:0] rd_tag_o;
  logic             rd_busy_o;
  logic             err_ovf_o;
  logic             err_coll_o;

  modport master (
    output rd_cmd_i, rd_tag_i, rx_dat_i, fifo_full_i, err_clr_i,
    input  rd_dat_o, rd_vld_o, rd_last_o, rd_tag_o, rd_busy_o, err_ovf_o, err_coll_o
  );

  modport slave (
    input  rd_cmd_i, rd_tag_i, rx_dat_i, fifo_full_i, err_clr_i,
    output rd_dat_o, rd_vld_o, rd_last_o, rd_tag_o, rd_busy_o, err_ovf_o, err_coll_o
  );

endinterface

// File: rtl/versatile_mem_ctrl_dly.sv
// Fixed-depth shift register with async clear; nz flags any non-zero stage so
// callers can tell whether anything is still in flight.
module versatile_mem_ctrl_dly #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk_0,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             nz
);

  logic [DEPTH-1:0][WIDTH-1:0] stg;

  always_ff @(posedge clk_0 or negedge rst_n) begin
    if (!rst_n) begin
      stg <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  assign q  = stg[DEPTH-1];
  assign nz = |stg;

endmodule

// File: rtl/versatile_mem_ctrl_ddr_rd_align.sv
// DDR2 read-return aligner: follows each READ through the CAS pipe and frames
// captured words into tagged bursts for the Rx FIFO, with sticky error flags.
module versatile_mem_ctrl_ddr_rd_align
  import versatile_mem_ctrl_ddr_rd_align_pkg::*;
#(
  parameter int CL    = CL_DEF,
  parameter int BL    = 4,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic clk_0,
  input  logic rst_n,
  versatile_mem_ctrl_ddr_rd_align_if.slave bus
);

  localparam int BW    = bl_words(BL);
  localparam int CNT_W = $clog2(BW + 1);

  logic [TAG_W:0]   arr;
  logic             arr_vld;
  logic [TAG_W-1:0] arr_tag;
  logic             pipe_busy;

  // Tag is zeroed with no command so that nz reflects only in-flight READs
  versatile_mem_ctrl_dly #(
    .DEPTH(CL),
    .WIDTH(TAG_W + 1)
  ) u_dly (
    .clk_0(clk_0),
    .rst_n(rst_n),
    .d    ({bus.rd_cmd_i, bus.rd_cmd_i ? bus.rd_tag_i : {TAG_W{1'b0}}}),
    .q    (arr),
    .nz   (pipe_busy)
  );

  assign arr_vld = arr[TAG_W];
  assign arr_tag = arr[TAG_W-1:0];

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [TAG_W-1:0] tag_q;
  logic [DAT_W-1:0] dat_q;
  logic             vld_q, last_q, ovf_q, coll_q;
  logic             beat, collide;

  assign beat    = arr_vld || (cnt > CNT_W'(1));
  assign collide = arr_vld && (cnt > CNT_W'(1));

  always_comb begin
    cnt_nxt = cnt;
    if (arr_vld)          cnt_nxt = CNT_W'(BW);
    else if (cnt != '0)   cnt_nxt = cnt - CNT_W'(1);
  end

  // A dropped word still consumes its beat so the burst framing stays intact
  always_ff @(posedge clk_0 or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      tag_q  <= '0;
      dat_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      ovf_q  <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      if (arr_vld) tag_q <= arr_tag;
      if (beat)    dat_q <= bus.rx_dat_i;
      vld_q  <= beat && !bus.fifo_full_i;
      last_q <= beat && (cnt_nxt == CNT_W'(1));
      ovf_q  <= (ovf_q && !bus.err_clr_i) || (beat && bus.fifo_full_i);
      coll_q <= (coll_q && !bus.err_clr_i) || collide;
    end
  end

  assign bus.rd_dat_o   = dat_q;
  assign bus.rd_vld_o   = vld_q;
  assign bus.rd_last_o  = last_q;
  assign bus.rd_tag_o   = tag_q;
  assign bus.rd_busy_o  = pipe_busy || (cnt != '0);
  assign bus.err_ovf_o  = ovf_q;
  assign bus.err_coll_o = coll_q;

endmodule
